// File: rtl/motion_arg_collector.sv
// Collects the X and Y arguments of a motion command through the argument subparser,
// and publishes both coordinates together only when the whole line was well formed.
`ifndef POS_X_BITS
`define POS_X_BITS 14
`endif
`ifndef PRECISE_POS_X_BITS
`define PRECISE_POS_X_BITS 22
`endif

// state  | meaning
// IDLE   | waiting for trigger, rdy high
// REQ_X  | requesting the X argument from the subparser
// WAIT_X | waiting for the X result
// REQ_Y  | requesting the Y argument from the subparser
// WAIT_Y | waiting for the Y result
// FINISH | one-cycle done pulse, result valid
module motion_arg_collector #(
    parameter int NUM_BITS         = `POS_X_BITS,
    parameter int PRECISE_NUM_BITS = `PRECISE_POS_X_BITS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clk_en,
    input  logic                        trigger,
    output logic                        rdy,
    output logic                        done,
    output logic                        success,
    output logic [1:0]                  err_code,
    output logic [NUM_BITS-1:0]         x,
    output logic [NUM_BITS-1:0]         y,
    output logic [PRECISE_NUM_BITS-1:0] precise_x,
    output logic [PRECISE_NUM_BITS-1:0] precise_y,
    output logic                        arg_trigger,
    output logic [7:0]                  arg_title,
    input  logic                        arg_rdy,
    input  logic                        arg_done,
    input  logic                        arg_success,
    input  logic                        arg_newline,
    input  logic                        arg_too_big,
    input  logic [NUM_BITS-1:0]         arg_num,
    input  logic [PRECISE_NUM_BITS-1:0] arg_precise_num
);

    localparam logic [7:0] CHAR_X = 8'h58;
    localparam logic [7:0] CHAR_Y = 8'h59;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ_X  = 3'd1;
    localparam logic [2:0] WAIT_X = 3'd2;
    localparam logic [2:0] REQ_Y  = 3'd3;
    localparam logic [2:0] WAIT_Y = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_MALFORMED = 2'd1;
    localparam logic [1:0] ERR_TOO_BIG   = 2'd2;
    localparam logic [1:0] ERR_LINE      = 2'd3;

    logic [2:0]                  state;
    logic [NUM_BITS-1:0]         tmp_x;
    logic [PRECISE_NUM_BITS-1:0] tmp_precise_x;

    assign rdy  = (state == IDLE);
    assign done = (state == FINISH);
    // Gated by clk_en so a frozen request never looks like a repeated trigger.
    assign arg_trigger = clk_en && arg_rdy && ((state == REQ_X) || (state == REQ_Y));
    assign arg_title   = ((state == REQ_Y) || (state == WAIT_Y)) ? CHAR_Y : CHAR_X;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            success       <= 1'b0;
            err_code      <= ERR_NONE;
            x             <= '0;
            y             <= '0;
            precise_x     <= '0;
            precise_y     <= '0;
            tmp_x         <= '0;
            tmp_precise_x <= '0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= REQ_X;
                        success  <= 1'b0;
                        err_code <= ERR_NONE;
                    end
                end
                REQ_X: if (arg_rdy) state <= WAIT_X;
                WAIT_X: begin
                    if (arg_done) begin
                        if (arg_too_big) begin
                            err_code <= ERR_TOO_BIG;
                            state    <= FINISH;
                        end else if (!arg_success) begin
                            err_code <= ERR_MALFORMED;
                            state    <= FINISH;
                        end else if (arg_newline) begin
                            err_code <= ERR_LINE;
                            state    <= FINISH;
                        end else begin
                            tmp_x         <= arg_num;
                            tmp_precise_x <= arg_precise_num;
                            state         <= REQ_Y;
                        end
                    end
                end
                REQ_Y: if (arg_rdy) state <= WAIT_Y;
                WAIT_Y: begin
                    // Y must be the last argument on the line.
                    if (arg_done) begin
                        state <= FINISH;
                        if (arg_too_big) begin
                            err_code <= ERR_TOO_BIG;
                        end else if (!arg_success) begin
                            err_code <= ERR_MALFORMED;
                        end else if (!arg_newline) begin
                            err_code <= ERR_LINE;
                        end else begin
                            x         <= tmp_x;
                            y         <= arg_num;
                            precise_x <= tmp_precise_x;
                            precise_y <= arg_precise_num;
                            success   <= 1'b1;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_motion_arg_collector.sv
// Directed bench for motion_arg_collector: the bench plays the argument subparser
// and checks outputs on the falling edge against hand-computed values.
module tb_motion_arg_collector;

    localparam int NB = 14;
    localparam int PB = 22;
    localparam logic [7:0] CX = 8'h58;
    localparam logic [7:0] CY = 8'h59;

    logic          clk = 1'b0;
    logic          reset, clk_en, trigger;
    logic          rdy, done, success;
    logic [1:0]    err_code;
    logic [NB-1:0] x, y;
    logic [PB-1:0] precise_x, precise_y;
    logic          arg_trigger;
    logic [7:0]    arg_title;
    logic          arg_rdy, arg_done, arg_success, arg_newline, arg_too_big;
    logic [NB-1:0] arg_num;
    logic [PB-1:0] arg_precise_num;

    int checks = 0;
    int errors = 0;
    int n_trig = 0;
    int n_done = 0;
    int t0, d0;

    motion_arg_collector #(.NUM_BITS(NB), .PRECISE_NUM_BITS(PB)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
        .rdy(rdy), .done(done), .success(success), .err_code(err_code),
        .x(x), .y(y), .precise_x(precise_x), .precise_y(precise_y),
        .arg_trigger(arg_trigger), .arg_title(arg_title),
        .arg_rdy(arg_rdy), .arg_done(arg_done), .arg_success(arg_success),
        .arg_newline(arg_newline), .arg_too_big(arg_too_big),
        .arg_num(arg_num), .arg_precise_num(arg_precise_num)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (arg_trigger) n_trig <= n_trig + 1;
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_collection();
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("trig_latency", 32'(arg_trigger), 32'd1);
        check("rdy_busy", 32'(rdy), 32'd0);
    endtask

    // Answer one subparser request, then leave the inputs holding garbage.
    task automatic arg_reply(input logic [7:0] title, input logic s, input logic tb,
                             input logic nl, input logic [NB-1:0] num,
                             input logic [PB-1:0] pnum);
        int k;
        k = 0;
        while (!arg_trigger && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("arg_trigger_seen", 32'(arg_trigger), 32'd1);
        check("arg_title_req", 32'(arg_title), 32'(title));
        @(negedge clk);
        check("arg_trigger_pulse", 32'(arg_trigger), 32'd0);
        check("arg_title_wait", 32'(arg_title), 32'(title));
        arg_done = 1'b1; arg_success = s; arg_too_big = tb; arg_newline = nl;
        arg_num = num; arg_precise_num = pnum;
        @(negedge clk);
        arg_done = 1'b0; arg_success = ~s; arg_too_big = ~tb; arg_newline = ~nl;
        arg_num = ~num; arg_precise_num = ~pnum;
    endtask

    task automatic finish_check(input logic s, input logic [1:0] e,
                                input logic [NB-1:0] ex, input logic [NB-1:0] ey,
                                input logic [PB-1:0] epx, input logic [PB-1:0] epy);
        check("done_pulse", 32'(done), 32'd1);
        check("success", 32'(success), 32'(s));
        check("err_code", 32'(err_code), 32'(e));
        check("x", 32'(x), 32'(ex));
        check("y", 32'(y), 32'(ey));
        check("precise_x", 32'(precise_x), 32'(epx));
        check("precise_y", 32'(precise_y), 32'(epy));
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        check("done_low", 32'(done), 32'd0);
        check("rdy_after", 32'(rdy), 32'd1);
        check("success_hold", 32'(success), 32'(s));
        @(negedge clk);
        check("trig_with_done_ignored", 32'(rdy), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdy"}, 32'(rdy), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_success"}, 32'(success), 32'd0);
        check({tag, "_err"}, 32'(err_code), 32'd0);
        check({tag, "_argtrig"}, 32'(arg_trigger), 32'd0);
        check({tag, "_title"}, 32'(arg_title), 32'(CX));
        check({tag, "_xy"}, {x, y, 4'h0}, 32'd0);
        check({tag, "_pxy"}, 32'(precise_x | precise_y), 32'd0);
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b1; trigger = 1'b0; arg_rdy = 1'b1;
        arg_done = 1'b0; arg_success = 1'b0; arg_newline = 1'b0; arg_too_big = 1'b0;
        arg_num = '0; arg_precise_num = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check_reset_values("rst");
        @(negedge clk);

        // "X123.45 Y12.34\n"
        t0 = n_trig; d0 = n_done;
        start_collection();
        arg_reply(CX, 1, 0, 0, 14'd123, 22'd31603);
        arg_reply(CY, 1, 0, 1, 14'd12, 22'd3159);
        finish_check(1, 2'd0, 14'd123, 14'd12, 22'd31603, 22'd3159);
        check("t1_trig_count", 32'(n_trig - t0), 32'd2);
        check("t1_done_count", 32'(n_done - d0), 32'd1);

        // "X-12.34 Y 8.5\n"
        start_collection();
        arg_reply(CX, 1, 0, 0, 14'h3FF4, 22'h3FF3A9);
        arg_reply(CY, 1, 0, 1, 14'd8, 22'd2176);
        finish_check(1, 2'd0, 14'h3FF4, 14'd8, 22'h3FF3A9, 22'd2176);

        // "X123\n": Y missing, no Y request
        t0 = n_trig;
        start_collection();
        arg_reply(CX, 1, 0, 1, 14'd123, 22'd31488);
        finish_check(0, 2'd3, 14'h3FF4, 14'd8, 22'h3FF3A9, 22'd2176);
        check("t3_trig_count", 32'(n_trig - t0), 32'd1);

        // "X12.a3": malformed
        start_collection();
        arg_reply(CX, 0, 0, 0, 14'd12, 22'd3072);
        finish_check(0, 2'd1, 14'h3FF4, 14'd8, 22'h3FF3A9, 22'd2176);

        // "X 8192.0": too big, priority over malformed
        start_collection();
        arg_reply(CX, 0, 1, 0, 14'd0, 22'd0);
        finish_check(0, 2'd2, 14'h3FF4, 14'd8, 22'h3FF3A9, 22'd2176);

        // "X1 Y2 Z3": trailing text after Y
        start_collection();
        arg_reply(CX, 1, 0, 0, 14'd1, 22'd256);
        arg_reply(CY, 1, 0, 0, 14'd2, 22'd512);
        finish_check(0, 2'd3, 14'h3FF4, 14'd8, 22'h3FF3A9, 22'd2176);

        // clk_en freeze in WAIT_X with a bad arg_done offered meanwhile
        start_collection();
        @(negedge clk);
        clk_en = 1'b0;
        arg_done = 1'b1; arg_too_big = 1'b1; arg_success = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frz_rdy", 32'(rdy), 32'd0);
            check("frz_done", 32'(done), 32'd0);
            check("frz_err", 32'(err_code), 32'd0);
            check("frz_title", 32'(arg_title), 32'(CX));
            check("frz_x", 32'(x), 32'h3FF4);
        end
        clk_en = 1'b1; arg_done = 1'b0;
        @(negedge clk);
        check("frz_still_wait", {29'd0, rdy, done, arg_trigger}, 32'd0);
        arg_done = 1'b1; arg_success = 1'b1; arg_too_big = 1'b0; arg_newline = 1'b0;
        arg_num = 14'd5; arg_precise_num = 22'd1280;
        @(negedge clk);
        arg_done = 1'b0;
        arg_reply(CY, 1, 0, 1, 14'd6, 22'd1536);
        finish_check(1, 2'd0, 14'd5, 14'd6, 22'd1280, 22'd1536);

        // reset in WAIT_Y, with clk_en low to show reset wins
        d0 = n_done;
        start_collection();
        arg_reply(CX, 1, 0, 0, 14'd77, 22'd19712);
        @(negedge clk);
        check("wait_y_title", 32'(arg_title), 32'(CY));
        reset = 1'b1; clk_en = 1'b0;
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b1;
        check_reset_values("midrst");
        @(negedge clk); @(negedge clk);
        check("midrst_no_done", 32'(n_done - d0), 32'd0);
        check("midrst_idle", 32'(rdy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/motion_arg_collector.md
MOTION_ARG_COLLECTOR -- requirements
Module: motion_arg_collector

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default `POS_X_BITS, width of integer coordinate.
REQ-002 The block SHALL have parameter PRECISE_NUM_BITS, default `PRECISE_POS_X_BITS, width of fixed-point coordinate.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clk_en  in  1  state advances only on cycles with clk_en=1; otherwise all registers hold.
REQ-006 trigger  in  1  start request from the command parser; sampled only in IDLE.
REQ-007 rdy  out  1  high only in IDLE.
REQ-008 done  out  1  one-cycle pulse at the end of a collection.
REQ-009 success  out  1  result of the last collection; valid from the done pulse until the next trigger.
REQ-010 err_code  out  2  0=none, 1=argument malformed, 2=argument too big, 3=line structure error.
REQ-011 x, y  out  NUM_BITS each  last successfully collected integer coordinates.
REQ-012 precise_x, precise_y  out  PRECISE_NUM_BITS each  last successfully collected fixed-point coordinates.
REQ-013 arg_trigger  out  1  trigger to the argument subparser (Subparser_IF master trigger).
REQ-014 arg_title  out  8  Char_t title expected by the subparser (CHAR_X or CHAR_Y).
REQ-015 arg_rdy, arg_done, arg_success, arg_newline, arg_too_big  in  1 each  subparser status.
REQ-016 arg_num  in  NUM_BITS and arg_precise_num  in  PRECISE_NUM_BITS  subparser results.

Function
REQ-017 The FSM SHALL have states IDLE, REQ_X, WAIT_X, REQ_Y, WAIT_Y, FINISH.
REQ-018 In IDLE, trigger=1 SHALL move the FSM to REQ_X and clear success and err_code.
REQ-019 In REQ_x/REQ_Y, the block SHALL drive arg_trigger=1 while arg_rdy=1, then move to WAIT_X/WAIT_Y on the next cycle.
REQ-020 arg_trigger SHALL be high for exactly one cycle per request.
REQ-021 arg_title SHALL be CHAR_X in REQ_X/WAIT_X and CHAR_Y in REQ_Y/WAIT_Y, and SHALL be stable for the whole request.
REQ-022 In WAIT_*, the block SHALL sample arg_* inputs only on the cycle arg_done=1.
REQ-023 WAIT_X exit: arg_success=0 -> err 1; arg_too_big=1 -> err 2 (takes priority over err 1); arg_newline=1 -> err 3 (Y missing); otherwise latch num/precise into temporary registers and go to REQ_Y.
REQ-024 WAIT_Y exit: same error checks; arg_newline=0 -> err 3 (trailing text); otherwise latch Y.
REQ-025 Any error SHALL go to FINISH with success=0, and x, y, precise_x and precise_y SHALL keep their previous values.
REQ-026 On a good Y, the block SHALL update x, y, precise_x and precise_y together, set success=1, and go to FINISH.
REQ-027 FINISH SHALL assert done for one cycle, then return to IDLE (rdy=1 the following cycle).
REQ-028 trigger while not in IDLE SHALL be ignored; trigger and done in the same cycle SHALL not start a new collection.
REQ-029 Latency from trigger (with arg_rdy=1) to arg_trigger SHALL be 1 cycle; from the Y arg_done to done SHALL be 1 cycle.
REQ-030 arg_done outside WAIT_* SHALL be ignored.

Reset
REQ-031 On reset: state=IDLE; rdy=1; done=0; success=0; err_code=0; arg_trigger=0; arg_title=CHAR_X; x, y, precise_x, precise_y and temporaries=0.
REQ-032 Reset during any state (including WAIT_*) SHALL abort immediately and hold the reset values the following cycle, with no done pulse.
REQ-033 Reset SHALL override clk_en.

Verification
REQ-034 The bench SHALL cover "X123.45 Y12.34\n" -> one done, success=1, err=0, x=123, y=12, precise values equal to the subparser outputs.
REQ-035 The bench SHALL cover "X-12.34 Y 8.5\n" -> success=1, x=-12 (two's complement), y=8.
REQ-036 The bench SHALL cover "X123\n" -> done, success=0, err=3, x/y unchanged from the previous test, and no Y request is issued.
REQ-037 The bench SHALL cover "X12.a3 ..." (arg_success=0) -> err=1; "X 8192.0 ..." (arg_too_big=1) -> err=2; outputs held.
REQ-038 The bench SHALL cover "X1 Y2 Z3" (newline=0 after Y) -> err=3, x/y held.
REQ-039 The bench SHALL cover reset asserted in WAIT_Y -> next cycle rdy=1, done=0, all outputs at reset values; clk_en=0 for 5 cycles mid-run -> state and outputs frozen.
